jtag_mem_bridge: RTL and testbench



---
 rtl/jtag_bridge_pkg.sv | 33 +++
 rtl/jtag_dr_shift.sv | 46 ++++
 rtl/jtag_mem_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_jtag_mem_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_bridge_pkg.sv
// -----------------------------------------------------------------------------
// jtag_bridge_pkg
// Shared definitions for the single-chain JTAG-to-memory bridge:
//   - DR frame command encodings (NOP, SET_ADDR, WRITE, READ)
//   - FSM state encodings
//   - DR frame field offsets
//   - bit positions of the status field in the captured frame
// Optional feature macro used by the bridge: JTAG_TIMEOUT_EN
// -----------------------------------------------------------------------------
package jtag_bridge_pkg;

   // Command field, frame bits [1:0]
   typedef enum logic [1:0] {
      CMD_NOP      = 2'b00,
      CMD_SET_ADDR = 2'b01,
      CMD_WRITE    = 2'b10,
      CMD_READ     = 2'b11
   } cmd_e;

   // Bridge FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   // Frame layout, LSB first: CMD then PAYLOAD
   localparam int FRAME_CMD_LSB     = 0;
   localparam int FRAME_CMD_W       = 2;
   localparam int FRAME_PAYLOAD_LSB = 2;

   // Status bits in the captured frame
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_ERR  = 1;

endpackage : jtag_bridge_pkg

// File: rtl/jtag_dr_shift.sv
// -----------------------------------------------------------------------------
// jtag_dr_shift
// Generic JTAG data register: parallel capture, LSB-first serial shift.
// Strobes must already be qualified with the chain's select.
// Ports:
//   clk       in   TCK
//   rst       in   synchronous active-high reset
//   capture   in   load cap_data into the register
//   shift     in   shift right, tdi enters at the MSB
//   tdi       in   serial data in
//   cap_data  in   W  parallel capture value
//   dr        out  W  current register contents
//   tdo       out  serial data out (= dr[0])
// -----------------------------------------------------------------------------
module jtag_dr_shift #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic         shift,
   input  logic         tdi,
   input  logic [W-1:0] cap_data,
   output logic [W-1:0] dr,
   output logic         tdo
);

   logic [W-1:0] dr_r;

   // Capture has priority; TAP strobes are mutually exclusive in practice.
   always_ff @(posedge clk) begin
      if (rst) begin
         dr_r <= '0;
      end else if (capture) begin
         dr_r <= cap_data;
      end else if (shift) begin
         dr_r <= {tdi, dr_r[W-1:1]};
      end else begin
         dr_r <= dr_r;
      end
   end

   assign dr  = dr_r;
   assign tdo = dr_r[0];

endmodule : jtag_dr_shift

// File: rtl/jtag_mem_bridge.sv
// -----------------------------------------------------------------------------
// jtag_mem_bridge
// JTAG-to-memory bridge on a single BSCANE2 USER chain, TCK domain only.
// One DATA_W+2 bit DR frame carries {PAYLOAD, CMD}. Accesses use a REQ/ACK
// handshake with address post-increment; a second command arriving while an
// access is outstanding is dropped and flagged in a sticky overrun bit.
// Optional feature: define JTAG_TIMEOUT_EN to abort an access after
// TIMEOUT_CYC cycles without MEM_ACK and flag a sticky error.
// Ports:
//   TCK                      in   test clock, all state on rising edge
//   RESET                    in   synchronous active-high reset
//   SEL                      in   USER instruction selects this chain
//   CAPTURE/SHIFT/UPDATE     in   TAP state strobes
//   TDI / TDO                in/out serial data
//   MEM_REQ                  out  access request, held until MEM_ACK
//   MEM_WE                   out  1 = write, 0 = read
//   ADDR                     out  ADDR_W access address
//   TO_MEM                   out  DATA_W write data
//   FROM_MEM                 in   DATA_W read data, taken with MEM_ACK
//   MEM_ACK                  in   access complete
//   BUSY                     out  access outstanding
// -----------------------------------------------------------------------------
module jtag_mem_bridge
   import jtag_bridge_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int ADDR_STEP   = DATA_W / 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              TCK,
   input  logic              RESET,
   input  logic              SEL,
   input  logic              CAPTURE,
   input  logic              SHIFT,
   input  logic              UPDATE,
   input  logic              TDI,
   output logic              TDO,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] TO_MEM,
   input  logic [DATA_W-1:0] FROM_MEM,
   input  logic              MEM_ACK,
   output logic              BUSY
);

   localparam int FRAME_W = DATA_W + 2;

   logic               capture_s;
   logic               shift_s;
   logic               update_s;
   logic [FRAME_W-1:0] dr_s;
   logic [FRAME_W-1:0] cap_data_s;
   logic [1:0]         cmd_s;
   logic [DATA_W-1:0]  payload_s;
   logic               nop_clr_s;
   logic               err_s;
   logic               err_set_s;

   logic [0:0]         state_r,   state_n;
   logic               mem_req_r, mem_req_n;
   logic               mem_we_r,  mem_we_n;
   logic               busy_r,    busy_n;
   logic               ovr_r,     ovr_n;
   logic [ADDR_W-1:0]  addr_r,    addr_n;
   logic [DATA_W-1:0]  to_mem_r,  to_mem_n;
   logic [DATA_W-1:0]  rdata_r,   rdata_n;

   assign capture_s = CAPTURE & SEL;
   assign shift_s   = SHIFT & SEL;
   assign update_s  = UPDATE & SEL;

   assign cmd_s     = dr_s[FRAME_CMD_LSB +: FRAME_CMD_W];
   assign payload_s = dr_s[FRAME_PAYLOAD_LSB +: DATA_W];
   assign nop_clr_s = update_s & (cmd_s == CMD_NOP) & payload_s[0];

   // Status sits in the low bits so a host sees BUSY/ERR first on TDO.
   assign cap_data_s = {rdata_r, (err_s | ovr_r), busy_r};

   jtag_dr_shift #(
      .W (FRAME_W)
   ) u_dr (
      .clk      (TCK),
      .rst      (RESET),
      .capture  (capture_s),
      .shift    (shift_s),
      .tdi      (TDI),
      .cap_data (cap_data_s),
      .dr       (dr_s),
      .tdo      (TDO)
   );

`ifdef JTAG_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt_r;
   logic             tmo_hit_s;
   logic             err_r;

   assign tmo_hit_s = (state_r == ST_REQ) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
   assign err_s     = err_r;

   // Counts REQ cycles without ACK; restarts from zero for every access.
   always_ff @(posedge TCK) begin
      if (RESET) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if ((state_r == ST_REQ) && !MEM_ACK && !tmo_hit_s) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end
   end

   // Sticky error: a timeout in the same cycle as a clear still leaves it set.
   always_ff @(posedge TCK) begin
      if (RESET) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end else if (nop_clr_s) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end
`else
   assign err_s = 1'b0;
`endif

   // Command decode and access FSM next-state logic.
   always_comb begin
      state_n   = state_r;
      mem_we_n  = mem_we_r;
      addr_n    = addr_r;
      to_mem_n  = to_mem_r;
      rdata_n   = rdata_r;
      ovr_n     = ovr_r & ~nop_clr_s;
      err_set_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (update_s) begin
               case (cmd_s)
                  CMD_SET_ADDR: addr_n = payload_s[ADDR_W-1:0];
                  CMD_WRITE: begin
                     to_mem_n = payload_s;
                     mem_we_n = 1'b1;
                     state_n  = ST_REQ;
                  end
                  CMD_READ: begin
                     mem_we_n = 1'b0;
                     state_n  = ST_REQ;
                  end
                  CMD_NOP: state_n = ST_IDLE;
                  default: state_n = ST_IDLE;
               endcase
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (MEM_ACK) begin
               state_n = ST_IDLE;
               addr_n  = addr_r + ADDR_W'(ADDR_STEP);
               if (!mem_we_r) begin
                  rdata_n = FROM_MEM;
               end else begin
                  rdata_n = rdata_r;
               end
            end
`ifdef JTAG_TIMEOUT_EN
            else if (tmo_hit_s) begin
               state_n   = ST_IDLE;
               err_set_s = 1'b1;
            end
`endif
            else begin
               state_n = ST_REQ;
            end
            // An UPDATE on the completing edge still sees REQ and is dropped.
            if (update_s && (cmd_s != CMD_NOP)) begin
               ovr_n = 1'b1;
            end else begin
               ovr_n = ovr_r & ~nop_clr_s;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      mem_req_n = (state_n == ST_REQ);
      busy_n    = (state_n == ST_REQ);
   end

   // Bridge state registers.
   always_ff @(posedge TCK) begin
      if (RESET) begin
         state_r   <= ST_IDLE;
         mem_req_r <= 1'b0;
         mem_we_r  <= 1'b0;
         busy_r    <= 1'b0;
         ovr_r     <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         to_mem_r  <= {DATA_W{1'b0}};
         rdata_r   <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_n;
         mem_req_r <= mem_req_n;
         mem_we_r  <= mem_we_n;
         busy_r    <= busy_n;
         ovr_r     <= ovr_n;
         addr_r    <= addr_n;
         to_mem_r  <= to_mem_n;
         rdata_r   <= rdata_n;
      end
   end

   assign MEM_REQ = mem_req_r;
   assign MEM_WE  = mem_we_r;
   assign BUSY    = busy_r;
   assign ADDR    = addr_r;
   assign TO_MEM  = to_mem_r;

endmodule : jtag_mem_bridge

// File: tb/tb_jtag_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_jtag_mem_bridge
// Drives DR scans through the bridge and checks captured frames and memory
// transactions against expectations queued when each command is issued.
// Build with JTAG_TIMEOUT_EN to also exercise the ACK timeout (TIMEOUT_CYC=16).
// -----------------------------------------------------------------------------
module tb_jtag_mem_bridge;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int FW = DW + 2;

   localparam logic [1:0] C_NOP  = 2'b00;
   localparam logic [1:0] C_SETA = 2'b01;
   localparam logic [1:0] C_WR   = 2'b10;
   localparam logic [1:0] C_RD   = 2'b11;

   logic          TCK, RESET, SEL, CAPTURE, SHIFT, UPDATE, TDI, TDO;
   logic          MEM_REQ, MEM_WE, MEM_ACK, BUSY;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] TO_MEM, FROM_MEM;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } mem_txn_t;

   mem_txn_t      exp_mem_q[$];
   logic [FW-1:0] exp_cap_q[$];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            ack_delay = 0;
   int            req_cnt   = 0;
   bit            resp_en   = 1'b1;
   logic [DW-1:0] rd_value  = '0;

   jtag_mem_bridge #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .ADDR_STEP   (4),
`ifdef JTAG_TIMEOUT_EN
      .TIMEOUT_CYC (16)
`else
      .TIMEOUT_CYC (1024)
`endif
   ) dut (
      .TCK      (TCK),
      .RESET    (RESET),
      .SEL      (SEL),
      .CAPTURE  (CAPTURE),
      .SHIFT    (SHIFT),
      .UPDATE   (UPDATE),
      .TDI      (TDI),
      .TDO      (TDO),
      .MEM_REQ  (MEM_REQ),
      .MEM_WE   (MEM_WE),
      .ADDR     (ADDR),
      .TO_MEM   (TO_MEM),
      .FROM_MEM (FROM_MEM),
      .MEM_ACK  (MEM_ACK),
      .BUSY     (BUSY)
   );

   initial begin
      TCK = 1'b0;
      forever #5 TCK = ~TCK;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] cap(input logic [DW-1:0] rd, input logic st, input logic bsy);
      return {rd, st, bsy};
   endfunction

   function automatic mem_txn_t txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_txn_t t;
      t.we   = we;
      t.addr = a;
      t.data = d;
      return t;
   endfunction

   // Memory model: checks each new request against the queue, ACKs after ack_delay.
   initial begin
      mem_txn_t t;
      MEM_ACK  = 1'b0;
      FROM_MEM = '0;
      forever begin
         @(negedge TCK);
         if (resp_en) begin
            MEM_ACK = 1'b0;
            if (MEM_REQ) begin
               if (req_cnt == 0) begin
                  check_eq("req_expected", 64'(exp_mem_q.size() > 0), 64'd1);
                  if (exp_mem_q.size() > 0) begin
                     t = exp_mem_q.pop_front();
                     check_eq("req_we", 64'(MEM_WE), 64'(t.we));
                     check_eq("req_addr", 64'(ADDR), 64'(t.addr));
                     if (t.we) check_eq("req_wdata", 64'(TO_MEM), 64'(t.data));
                  end
               end
               if (ack_delay >= 0 && req_cnt >= ack_delay) begin
                  MEM_ACK  = 1'b1;
                  FROM_MEM = rd_value;
               end
               req_cnt++;
            end else begin
               req_cnt = 0;
            end
         end
      end
   end

   // One full DR scan: capture, shift the frame in, update; checks the captured frame.
   task automatic scan(input string tag, input logic [1:0] cmd, input logic [DW-1:0] payload,
                       input logic [FW-1:0] exp_cap);
      logic [FW-1:0] din, dout, e;
      din = {payload, cmd};
      exp_cap_q.push_back(exp_cap);
      @(negedge TCK);
      SEL = 1'b1; CAPTURE = 1'b1;
      @(negedge TCK);
      CAPTURE = 1'b0; SHIFT = 1'b1;
      for (int i = 0; i < FW; i++) begin
         TDI     = din[i];
         dout[i] = TDO;
         @(negedge TCK);
      end
      SHIFT = 1'b0; UPDATE = 1'b1;
      @(negedge TCK);
      UPDATE = 1'b0; SEL = 1'b0; TDI = 1'b0;
      e = exp_cap_q.pop_front();
      check_eq(tag, 64'(dout), 64'(e));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (!MEM_REQ) break;
         @(negedge TCK);
      end
      check_eq(tag, 64'(MEM_REQ), 64'd0);
   endtask

   initial begin
      RESET = 1'b1; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
      repeat (3) @(negedge TCK);
      RESET = 1'b0;
      check_eq("rst_req",   64'(MEM_REQ), 64'd0);
      check_eq("rst_we",    64'(MEM_WE),  64'd0);
      check_eq("rst_addr",  64'(ADDR),    64'd0);
      check_eq("rst_tomem", 64'(TO_MEM),  64'd0);
      check_eq("rst_busy",  64'(BUSY),    64'd0);
      check_eq("rst_tdo",   64'(TDO),     64'd0);

      // Write with ACK three cycles after the first REQ cycle
      scan("cap_seta100", C_SETA, 32'h0000_0100, cap(32'h0, 1'b0, 1'b0));
      check_eq("addr_100", 64'(ADDR), 64'h100);
      ack_delay = 3;
      exp_mem_q.push_back(txn(1'b1, 32'h100, 32'hDEAD_BEEF));
      scan("cap_wr", C_WR, 32'hDEAD_BEEF, cap(32'h0, 1'b0, 1'b0));
      check_eq("wr_req",   64'(MEM_REQ), 64'd1);
      check_eq("wr_we",    64'(MEM_WE),  64'd1);
      check_eq("wr_tomem", 64'(TO_MEM),  64'hDEAD_BEEF);
      check_eq("wr_busy",  64'(BUSY),    64'd1);
      wait_idle("wr_done");
      check_eq("addr_104", 64'(ADDR), 64'h104);
      check_eq("wr_busy_clr", 64'(BUSY), 64'd0);

      // Read with immediate ACK; data appears on the following scan
      scan("cap_seta200", C_SETA, 32'h0000_0200, cap(32'h0, 1'b0, 1'b0));
      ack_delay = 0;
      rd_value  = 32'h1234_5678;
      exp_mem_q.push_back(txn(1'b0, 32'h200, 32'h0));
      scan("cap_rd", C_RD, 32'h0, cap(32'h0, 1'b0, 1'b0));
      check_eq("rd_we", 64'(MEM_WE), 64'd0);
      wait_idle("rd_done");
      check_eq("addr_204", 64'(ADDR), 64'h204);
      scan("cap_rdata", C_NOP, 32'h0, cap(32'h1234_5678, 1'b0, 1'b0));

      // Overrun: commands while an access is held are dropped and flagged
      ack_delay = -1;
      exp_mem_q.push_back(txn(1'b1, 32'h204, 32'hA5A5_A5A5));
      scan("cap_wr_hold", C_WR, 32'hA5A5_A5A5, cap(32'h1234_5678, 1'b0, 1'b0));
      check_eq("hold_busy", 64'(BUSY), 64'd1);
      scan("cap_ovr_busy", C_WR, 32'h1111_1111, cap(32'h1234_5678, 1'b0, 1'b1));
      check_eq("ovr_tomem", 64'(TO_MEM), 64'hA5A5_A5A5);
      check_eq("ovr_addr",  64'(ADDR),   64'h204);
      scan("cap_ovr_set", C_SETA, 32'h0000_0999, cap(32'h1234_5678, 1'b1, 1'b1));
      check_eq("ovr_seta", 64'(ADDR), 64'h204);
      ack_delay = 0;
      wait_idle("ovr_release");
      check_eq("addr_208", 64'(ADDR), 64'h208);
      scan("cap_ovr_idle", C_NOP, 32'h1, cap(32'h1234_5678, 1'b1, 1'b0));
      scan("cap_ovr_clr", C_NOP, 32'h0, cap(32'h1234_5678, 1'b0, 1'b0));

      // Address wrap at the top of the address space
      scan("cap_setaff", C_SETA, 32'hFFFF_FFFC, cap(32'h1234_5678, 1'b0, 1'b0));
      ack_delay = 1;
      exp_mem_q.push_back(txn(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D));
      scan("cap_wr_wrap", C_WR, 32'h0BAD_F00D, cap(32'h1234_5678, 1'b0, 1'b0));
      wait_idle("wrap_done");
      check_eq("addr_wrap", 64'(ADDR), 64'h0);

      // Reset in the middle of an access
      scan("cap_seta40", C_SETA, 32'h0000_0040, cap(32'h1234_5678, 1'b0, 1'b0));
      ack_delay = -1;
      exp_mem_q.push_back(txn(1'b1, 32'h40, 32'h55AA_55AA));
      scan("cap_wr_rst", C_WR, 32'h55AA_55AA, cap(32'h1234_5678, 1'b0, 1'b0));
      check_eq("pre_rst_req", 64'(MEM_REQ), 64'd1);
      RESET = 1'b1;
      @(negedge TCK);
      RESET = 1'b0;
      check_eq("mid_rst_req",   64'(MEM_REQ), 64'd0);
      check_eq("mid_rst_we",    64'(MEM_WE),  64'd0);
      check_eq("mid_rst_addr",  64'(ADDR),    64'd0);
      check_eq("mid_rst_tomem", 64'(TO_MEM),  64'd0);
      check_eq("mid_rst_busy",  64'(BUSY),    64'd0);
      check_eq("mid_rst_tdo",   64'(TDO),     64'd0);
      resp_en  = 1'b0;
      FROM_MEM = 32'hCAFE_F00D;
      MEM_ACK  = 1'b1;
      @(negedge TCK);
      MEM_ACK  = 1'b0;
      resp_en  = 1'b1;
      check_eq("late_ack_addr", 64'(ADDR),    64'd0);
      check_eq("late_ack_req",  64'(MEM_REQ), 64'd0);
      scan("cap_after_rst", C_NOP, 32'h0, cap(32'h0, 1'b0, 1'b0));

`ifdef JTAG_TIMEOUT_EN
      begin
         int cnt;
         scan("cap_seta300", C_SETA, 32'h0000_0300, cap(32'h0, 1'b0, 1'b0));
         ack_delay = -1;
         exp_mem_q.push_back(txn(1'b1, 32'h300, 32'h77));
         scan("cap_wr_tmo", C_WR, 32'h77, cap(32'h0, 1'b0, 1'b0));
         cnt = 0;
         for (int i = 0; i < 100; i++) begin
            if (!MEM_REQ) break;
            cnt++;
            @(negedge TCK);
         end
         check_eq("tmo_req_cycles", 64'(cnt), 64'd16);
         check_eq("tmo_addr", 64'(ADDR), 64'h300);
         check_eq("tmo_busy", 64'(BUSY), 64'd0);
         scan("cap_tmo_err", C_NOP, 32'h1, cap(32'h0, 1'b1, 1'b0));
         scan("cap_tmo_clr", C_NOP, 32'h0, cap(32'h0, 1'b0, 1'b0));
      end
`endif

      check_eq("mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_jtag_mem_bridge
